bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of BRAM and stream data.
REQ-002 Parameter ADDR_WIDTH, default 10, BRAM address width; block length up to 2^ADDR_WIDTH words.
REQ-003 The block SHALL use one clock, i_clk, with a synchronous, active-high reset, i_rst.
REQ-004 Ports SHALL be, in order:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start-transfer strobe
- i_base_addr  in  ADDR_WIDTH  first BRAM word address
- i_len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- bram_port  bram_port_if.master  -  BRAM read port: en, we, addr out; rd_data in
- o_tdata  out  DATA_WIDTH  stream data
- o_tvalid  out  1  stream data valid
- o_tlast  out  1  final word of transfer
- i_tready  in  1  downstream ready

Function
REQ-005 The block SHALL be a BRAM-to-stream reader: it reads i_len consecutive words starting at i_base_addr and emits them in address order on the valid/ready stream.
REQ-006 bram_port.we SHALL be held 0 at all times; bram_port.wr_data SHALL be held 0.
REQ-007 FSM states SHALL be IDLE, READ and DRAIN.
- IDLE -> READ on i_start with i_len != 0.
- READ -> DRAIN after the last read is issued.
- DRAIN -> IDLE on the last beat handshake.
REQ-008 i_start SHALL be sampled only in IDLE; i_start while o_busy=1 SHALL be ignored, and the transfer in progress SHALL be unaffected.
REQ-009 i_start with i_len=0 SHALL produce o_done=1 on the next cycle, with no BRAM reads and no stream beats; o_busy SHALL stay 0.
REQ-010 The BRAM read latency SHALL be taken as 1 cycle: rd_data for an address presented with en=1 in cycle k is valid in cycle k+1.
REQ-011 Start timing: with i_start accepted in cycle T and i_tready=1, en=1 with addr=i_base_addr SHALL appear in T+1, and the first o_tvalid in T+3.
REQ-012 Read data SHALL enter a 2-entry output FIFO; o_tdata/o_tvalid SHALL come from the FIFO head.
REQ-013 Credit rule: a read SHALL be issued only when (FIFO occupancy + reads in flight − pop this cycle) < 2, so data is never dropped under backpressure.
REQ-014 With i_tready held 1, the block SHALL sustain one beat per cycle after the first beat.
REQ-015 Read addresses SHALL increment by 1 modulo 2^ADDR_WIDTH (base 1023 with length 3 reads 1023, 0, 1).
REQ-016 o_tlast SHALL be 1 exactly on beat i_len−1; o_tdata, o_tvalid and o_tlast SHALL hold stable while o_tvalid=1 and i_tready=0.
REQ-017 o_busy SHALL be 1 from the cycle after start acceptance until the last beat handshake.
REQ-018 o_done SHALL pulse for 1 cycle in the cycle after the last beat handshake; o_busy SHALL be 0 in that same cycle.
REQ-019 i_base_addr and i_len SHALL be latched at start acceptance; later changes to them SHALL be ignored.

Reset
REQ-020 While i_rst=1, at the next edge: state=IDLE, FIFO flushed, in-flight reads discarded, and o_busy, o_done, o_tvalid, o_tlast, bram_port.en and bram_port.we all 0; o_tdata=0.
REQ-021 Reset mid-transfer SHALL abort the transfer without an o_done pulse; a read returning after reset SHALL be discarded.

Structure
REQ-022 The FSM state enum and the FIFO depth constant (2) SHALL live in package bram_stream_pkg.
REQ-023 The output FIFO SHALL be sub-module stream_fifo2 (2 entries, push/pop, occupancy output, simultaneous push and pop legal when not empty).

Verification
REQ-024 BRAM preloaded mem[i]=i+0x100; start with base=4, len=8, i_tready=1 -> beats 0x104..0x10B on consecutive cycles, first beat at T+3, tlast on 0x10B, o_done one cycle later.
REQ-025 base=1022, len=4 -> beats mem[1022], mem[1023], mem[0], mem[1] in that order.
REQ-026 len=16 with i_tready toggling pseudo-randomly (50%) -> all 16 words in order, none duplicated or lost, tdata stable while stalled, at most 2 reads outstanding.
REQ-027 len=0 -> o_done at T+1, no en, no tvalid; i_start during a len=8 transfer -> ignored, exactly 8 beats.
REQ-028 len=1024, base=0 -> 1024 beats, tlast only on beat 1023.
REQ-029 i_rst asserted after beat 3 of a len=10 transfer -> next cycle all outputs 0, no o_done; a new start with len=2 then completes normally.

Source files
------------

// File: rtl/bram_stream_pkg.sv
// ----------------------------------------------------------------------------
// bram_stream_pkg
// Shared definitions for the BRAM-to-stream reader:
//   state_t    - reader control states (idle, issuing reads, draining FIFO)
//   FIFO_DEPTH - depth of the output FIFO; also the read-credit limit
// ----------------------------------------------------------------------------
package bram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_port_if.sv
// ----------------------------------------------------------------------------
// bram_port_if
// Single BRAM port bundle.
//   en, we, addr, wr_data : driven by the master
//   rd_data               : returned by the memory, one cycle after en
// ----------------------------------------------------------------------------
interface bram_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) ();
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (output en, output we, output addr, output wr_data, input rd_data);
    modport slave  (input en, input we, input addr, input wr_data, output rd_data);
endinterface

// File: rtl/stream_fifo2.sv
// ----------------------------------------------------------------------------
// stream_fifo2
// Two-entry FIFO with occupancy output.
//   i_clk, i_rst : clock, synchronous active-high reset (flushes contents)
//   i_push       : write i_data (ignored when full without a pop)
//   i_data       : write data
//   i_pop        : discard head entry (ignored when empty)
//   o_data       : head entry
//   o_count      : occupancy 0..2
// Push and pop in the same cycle are legal when not empty.
// ----------------------------------------------------------------------------
module stream_fifo2
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != FULL_COUNT) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: the occupancy count alone decides validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// ----------------------------------------------------------------------------
// bram_stream_reader
// Reads i_len consecutive BRAM words from i_base_addr (address wraps modulo
// 2^ADDR_WIDTH) and emits them in order on a valid/ready stream.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : start strobe, sampled only while idle
//   i_base_addr       : first word address (latched at start)
//   i_len             : word count 0..2^ADDR_WIDTH (latched at start)
//   o_busy            : transfer in progress
//   o_done            : one-cycle pulse after the last beat (or after a
//                       zero-length start)
//   bram_port         : BRAM read port, 1-cycle read latency, never writes
//   o_tdata/o_tvalid/o_tlast/i_tready : output stream
// ----------------------------------------------------------------------------
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    bram_port_if.master           bram_port,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  i_tready
);

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_rd_left;
    logic [ADDR_WIDTH:0]   r_beat_left;
    logic                  r_rd_vld_p1;

    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic [1:0]            w_fifo_count;
    logic                  w_fifo_valid;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic [2:0]            w_limit;
    logic                  w_rd_issue;

    assign w_fifo_valid = (w_fifo_count != 2'd0);
    assign w_pop        = w_fifo_valid && i_tready;

    // Read credit: words held plus words in flight, less the word leaving
    // this cycle, must stay below the FIFO depth. Written as an addition on
    // the limit side so no unsigned underflow can occur.
    assign w_level    = {1'b0, w_fifo_count} + {2'b00, r_rd_vld_p1};
    assign w_limit    = 3'(FIFO_DEPTH) + {2'b00, w_pop};
    assign w_rd_issue = !i_rst && (r_state == ST_READ) && (w_level < w_limit);

    // ---- stage p0: read issue / control ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_rd_left   <= '0;
            r_beat_left <= '0;
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_rd_vld_p1 <= w_rd_issue;
            if (w_pop) r_beat_left <= r_beat_left - LEN_ONE;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= ST_READ;
                            r_busy      <= 1'b1;
                            r_addr      <= i_base_addr;
                            r_rd_left   <= i_len;
                            r_beat_left <= i_len;
                        end
                    end
                end
                ST_READ: begin
                    if (w_rd_issue) begin
                        r_addr    <= r_addr + ADDR_ONE;
                        r_rd_left <= r_rd_left - LEN_ONE;
                        if (r_rd_left == LEN_ONE) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last beat can only leave after the last read, so
                    // completion is detected here only.
                    if (w_pop && (r_beat_left == LEN_ONE)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---- stage p1: BRAM data returns and enters the FIFO ----
    stream_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_rd_vld_p1),
        .i_data  (bram_port.rd_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    // ---- stage p2: FIFO head drives the stream ----
    assign o_tvalid = w_fifo_valid;
    assign o_tdata  = w_fifo_valid ? w_fifo_data : '0;
    assign o_tlast  = w_fifo_valid && (r_beat_left == LEN_ONE);
    assign o_busy   = r_busy;
    assign o_done   = r_done;

    assign bram_port.en      = w_rd_issue;
    assign bram_port.we      = 1'b0;
    assign bram_port.addr    = r_addr;
    assign bram_port.wr_data = '0;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, tvalid, tlast;
    logic [DW-1:0] tdata;
    logic          tready = 1'b1;

    bram_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bram ();

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .bram_port   (bram),
        .o_tdata     (tdata),
        .o_tvalid    (tvalid),
        .o_tlast     (tlast),
        .i_tready    (tready)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] mem [MEMSZ];
    beat_t         exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            en_count = 0;
    int            beat_count = 0;
    int            issued = 0;
    int            popped = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with one-cycle read latency
    always @(posedge clk) begin
        if (bram.en) bram.rd_data <= mem[bram.addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard: samples just after the falling edge
    logic          p_stall = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          p_last = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        #1;
        if (rst) begin
            exp_q.delete();
            issued  = 0;
            popped  = 0;
            p_stall = 1'b0;
        end else begin
            chk("we_zero", {bram.we, bram.wr_data}, 0);
            if (p_stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, p_data);
                chk("stall_last", tlast, p_last);
            end
            if (bram.en) begin
                en_count++;
                issued++;
            end
            if (tvalid && tready) begin
                beat_count++;
                popped++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.data);
                    chk("tlast", tlast, e.last);
                end
            end
            if (bram.en) chk("outstanding_le2", (issued - popped) <= 2, 1);
            if (done) begin
                chk("done_busy_low", busy, 0);
                chk("done_queue_empty", exp_q.size(), 0);
            end
            p_stall = tvalid && !tready;
            p_data  = tdata;
            p_last  = tlast;
        end
    end

    // Reference model: the expected stream is mem[(base+i) mod 2^AW]
    task automatic start_xfer(input int b, input int l, input bit push_exp);
        @(negedge clk);
        start = 1'b1;
        base  = AW'(b);
        len   = (AW + 1)'(l);
        if (push_exp) begin
            for (int i = 0; i < l; i++) begin
                beat_t e;
                e.data = mem[(b + i) % MEMSZ];
                e.last = (i == l - 1);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
        base  = AW'($urandom);
        len   = (AW + 1)'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int at_cyc);
        at_cyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (done) begin
                at_cyc = cyc;
                break;
            end
        end
        chk("done_within_budget", at_cyc >= 0, 1);
        tready = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_tdata"}, tdata, 0);
        chk({tag, "_en"}, bram.en, 0);
        chk({tag, "_we"}, bram.we, 0);
    endtask

    initial begin
        int t1, at, b0, e0, found;

        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'(i + 32'h100);

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // base=4 len=8, full-rate timing
        start_xfer(4, 8, 1);
        #2;
        t1 = cyc;
        chk("t1_en", bram.en, 1);
        chk("t1_addr", bram.addr, 4);
        chk("t1_busy", busy, 1);
        @(negedge clk); #2;
        chk("t2_tvalid", tvalid, 0);
        @(negedge clk); #2;
        chk("t3_tvalid", tvalid, 1);
        chk("t3_tdata", tdata, 32'h104);
        wait_done(40, 0, at);
        chk("done_at_t11", at - t1, 10);
        @(negedge clk); #2;
        chk("done_one_cycle", done, 0);

        // Address wrap
        start_xfer(1022, 4, 1);
        wait_done(40, 0, at);

        // Random backpressure, len=16
        start_xfer(int'($urandom_range(0, MEMSZ - 1)), 16, 1);
        wait_done(300, 1, at);

        // Zero length
        e0 = en_count;
        b0 = beat_count;
        start_xfer(5, 0, 0);
        #2;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        repeat (4) @(negedge clk);
        #2;
        chk("len0_no_en", en_count - e0, 0);
        chk("len0_no_beat", beat_count - b0, 0);

        // Start while busy is ignored
        e0 = en_count;
        b0 = beat_count;
        start_xfer(100, 8, 1);
        @(negedge clk);
        start = 1'b1;
        base  = 10'd7;
        len   = 11'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, 0, at);
        chk("ignore_beats", beat_count - b0, 8);
        chk("ignore_reads", en_count - e0, 8);

        // Several random transfers under backpressure
        for (int n = 0; n < 6; n++) begin
            start_xfer(int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(1, 40)), 1);
            wait_done(400, 1, at);
        end

        // Full-memory transfer
        b0 = beat_count;
        start_xfer(0, 1024, 1);
        wait_done(1200, 0, at);
        chk("len1024_beats", beat_count - b0, 1024);

        // Reset mid-transfer
        b0 = beat_count;
        start_xfer(200, 10, 1);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            if (beat_count - b0 >= 4) begin
                found = 1;
                break;
            end
            @(negedge clk);
            #2;
        end
        chk("reached_beat3", found, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_outputs_zero("midrst");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            chk("post_rst_no_done", done, 0);
            chk("post_rst_no_tvalid", tvalid, 0);
        end
        b0 = beat_count;
        start_xfer(30, 2, 1);
        wait_done(40, 0, at);
        chk("after_rst_beats", beat_count - b0, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
